// File: rtl/spi_master_param_top.sv
// Wishbone-slave SPI master: configurable word width, TX/RX FIFOs,
// slave-select count, all four CPOL/CPHA modes, bit order and clock divider.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sck at CPOL, waiting for SPE and a queued TX word
// LOAD  | pop TX word, latch mode/divider for this word, 1 cycle
// LEAD  | sck away from CPOL for DIV+1 cycles
// TRAIL | sck back at CPOL for DIV+1 cycles, then next bit or DONE
// DONE  | push RX word, set SPIF, 1 cycle
`timescale 1ns/1ps
module spi_master_param_top #(
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int NSS        = 4,
   parameter int DIV_W      = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic [2:0]     adr_i,
   input  logic           cyc_i,
   input  logic           stb_i,
   input  logic           we_i,
   input  logic [DW-1:0]  dat_i,
   output logic [DW-1:0]  dat_o,
   output logic           ack_o,
   output logic           inta_o,
   output logic           sck_o,
   output logic           mosi_o,
   input  logic           miso_i,
   output logic [NSS-1:0] ss_n_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(DW);

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_LEAD, ST_TRAIL, ST_DONE} state_t;
   state_t state, state_nx;

   logic             spie, spe, lsbf, cpol, cpha, spif, wcol, rovr;
   logic [DIV_W-1:0] div_r, div_l, cnt;
   logic [NSS-1:0]   ss_r;
   logic             cpol_l, cpha_l, lsbf_l;
   logic [DW-1:0]    tx_sh, rx_sh;
   logic [BW-1:0]    bitcnt;

   logic [DW-1:0]    tx_mem [FIFO_DEPTH];
   logic [DW-1:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp;
   logic [AW:0]      tx_cnt, rx_cnt;
   logic             tx_full, tx_empty, rx_full, rx_empty;

   logic             req, acc, wr, rd, pop_ok, abort;
   logic             wr_ctrl, wr_stat, wr_data, wr_div, wr_ss;
   logic             tx_push, tx_pop, rx_push, rx_pop, done, sample, shift;
   logic [7:0]       wdat8, ctrl8, stat8;
   logic [DW-1:0]    rd_mux;

   assign tx_full  = (tx_cnt == (AW+1)'(FIFO_DEPTH));
   assign tx_empty = (tx_cnt == '0);
   assign rx_full  = (rx_cnt == (AW+1)'(FIFO_DEPTH));
   assign rx_empty = (rx_cnt == '0);

   // Register side effects land on the ack cycle, while the master still holds the request.
   assign req     = cyc_i & stb_i & ~ack_o;
   assign acc     = cyc_i & stb_i & ack_o;
   assign wr      = acc & we_i;
   assign rd      = acc & ~we_i;
   assign wdat8   = 8'(dat_i);
   assign wr_ctrl = wr & (adr_i == 3'd0);
   assign wr_stat = wr & (adr_i == 3'd1);
   assign wr_data = wr & (adr_i == 3'd2);
   assign wr_div  = wr & (adr_i == 3'd3);
   assign wr_ss   = wr & (adr_i == 3'd4);
   assign abort   = wr_ctrl & ~wdat8[6];
   assign tx_push = wr_data & ~tx_full;
   assign rx_push = done & ~rx_full;
   assign rx_pop  = rd & (adr_i == 3'd2) & pop_ok;

   assign ctrl8  = {spie, spe, lsbf, 1'b0, cpol, cpha, 2'b00};
   assign stat8  = {spif, wcol, rovr, 1'b0, tx_full, tx_empty, rx_full, rx_empty};
   assign ss_n_o = ~ss_r;
   assign mosi_o = lsbf_l ? tx_sh[0] : tx_sh[DW-1];

   // Read data mux, captured into dat_o when the request is first seen.
   always_comb begin
      rd_mux = '0;
      case (adr_i)
         3'd0: rd_mux = DW'(ctrl8);
         3'd1: rd_mux = DW'(stat8);
         3'd2: rd_mux = rx_empty ? '0 : rx_mem[rx_rp];
         3'd3: rd_mux = DW'(8'(div_r));
         3'd4: rd_mux = DW'(ss_r);
         default: rd_mux = '0;
      endcase
   end

   // Bus handshake: one-cycle ack, registered read data.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_o  <= 1'b0;
         dat_o  <= '0;
         pop_ok <= 1'b0;
      end else begin
         ack_o <= req;
         if (req) begin
            dat_o  <= rd_mux;
            pop_ok <= (adr_i == 3'd2) & ~rx_empty;
         end
      end
   end

   // Control/status registers and interrupt.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         {spie, spe, lsbf, cpol, cpha} <= '0;
         {spif, wcol, rovr}            <= '0;
         div_r  <= '0;
         ss_r   <= '0;
         inta_o <= 1'b0;
      end else begin
         if (wr_ctrl) {spie, spe, lsbf, cpol, cpha} <= {wdat8[7:5], wdat8[3:2]};
         if (wr_div)  div_r <= DIV_W'(wdat8);
         if (wr_ss)   ss_r  <= NSS'(wdat8);
         spif   <= (done & ~abort) | (spif & ~(wr_stat & wdat8[7]));
         wcol   <= (wr_data & tx_full) | (wcol & ~(wr_stat & wdat8[6]));
         rovr   <= (done & rx_full) | (rovr & ~(wr_stat & wdat8[5]));
         inta_o <= spie & spif;
      end
   end

   // FIFO pointers and occupancy; a CTRL write clearing SPE flushes both.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
         rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      end else if (abort) begin
         tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
         rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + AW'(1);
         if (tx_pop)  tx_rp <= tx_rp + AW'(1);
         if (tx_push & ~tx_pop) tx_cnt <= tx_cnt + (AW+1)'(1);
         else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - (AW+1)'(1);
         if (rx_push) rx_wp <= rx_wp + AW'(1);
         if (rx_pop)  rx_rp <= rx_rp + AW'(1);
         if (rx_push & ~rx_pop) rx_cnt <= rx_cnt + (AW+1)'(1);
         else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - (AW+1)'(1);
      end
   end

   // FIFO storage, no reset needed.
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wp] <= dat_i;
      if (rx_push) rx_mem[rx_wp] <= rx_sh;
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next state and per-cycle strobes; an abort overrides everything.
   always_comb begin
      state_nx = state;
      tx_pop   = 1'b0;
      done     = 1'b0;
      sample   = 1'b0;
      shift    = 1'b0;
      case (state)
         ST_IDLE: if (spe && !tx_empty) state_nx = ST_LOAD;
         ST_LOAD: begin
            tx_pop   = 1'b1;
            state_nx = ST_LEAD;
         end
         ST_LEAD: if (cnt == '0) begin
            sample   = ~cpha_l;
            state_nx = ST_TRAIL;
         end
         ST_TRAIL: if (cnt == '0) begin
            sample = cpha_l;
            if (bitcnt != '0) begin
               shift    = 1'b1;
               state_nx = ST_LEAD;
            end else begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = (spe && !tx_empty) ? ST_LOAD : ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (abort) begin
         state_nx = ST_IDLE;
         tx_pop   = 1'b0;
         done     = 1'b0;
         sample   = 1'b0;
         shift    = 1'b0;
      end
   end

   // Shift datapath and half-period down-counter; mode is frozen per word at LOAD.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         tx_sh  <= '0;
         rx_sh  <= '0;
         cnt    <= '0;
         div_l  <= '0;
         bitcnt <= '0;
         {cpol_l, cpha_l, lsbf_l} <= '0;
      end else if (tx_pop) begin
         tx_sh  <= tx_mem[tx_rp];
         {cpol_l, cpha_l, lsbf_l} <= {cpol, cpha, lsbf};
         div_l  <= div_r;
         cnt    <= div_r;
         bitcnt <= BW'(DW-1);
      end else begin
         if (state == ST_LEAD || state == ST_TRAIL)
            cnt <= (cnt == '0) ? div_l : cnt - DIV_W'(1);
         if (shift) begin
            tx_sh  <= lsbf_l ? (tx_sh >> 1) : (tx_sh << 1);
            bitcnt <= bitcnt - BW'(1);
         end
         if (sample)
            rx_sh <= lsbf_l ? {miso_i, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], miso_i};
      end
   end

   // SPI clock: idle level in IDLE/LOAD/DONE, inverted only during LEAD.
   always_comb begin
      case (state)
         ST_LEAD:           sck_o = ~cpol_l;
         ST_TRAIL, ST_DONE: sck_o = cpol_l;
         default:           sck_o = cpol;
      endcase
   end
endmodule

// File: tb/tb_spi_master_param_top.sv
// Scoreboard bench for spi_master_param_top (DW=8, FIFO_DEPTH=4, NSS=4).
`timescale 1ns/1ps
module tb_spi_master_param_top;
   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [2:0] adr_i;
   logic       cyc_i, stb_i, we_i;
   logic [7:0] dat_i, dat_o;
   logic       ack_o, inta_o, sck_o, mosi_o, miso_i;
   logic [3:0] ss_n_o;

   spi_master_param_top #(.DW(8), .FIFO_DEPTH(4), .NSS(4), .DIV_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .cyc_i(cyc_i), .stb_i(stb_i),
      .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .inta_o(inta_o),
      .sck_o(sck_o), .mosi_o(mosi_o), .miso_i(miso_i), .ss_n_o(ss_n_o));

   always #5 clk_i = ~clk_i;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   string      name_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Read monitor: every read ack pops one expected value.
   always @(negedge clk_i) begin
      string      n;
      logic [7:0] e;
      if (ack_o && cyc_i && stb_i && !we_i) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_read: got 0x%0h expected none", dat_o);
         end else begin
            n = name_q.pop_front();
            e = exp_q.pop_front();
            check(n, 32'(dat_o), 32'(e));
         end
      end
   end

   // Slave model and sck edge accounting.
   logic       loop_en, cpol_tb, s_cpha, s_lsbf, rec_en;
   logic [7:0] s_word, s_rx;
   int         cnt_lead, cnt_trail;
   time        rise_q[$];

   always @(sck_o) begin
      logic lead;
      lead = (sck_o !== cpol_tb);
      if (lead) cnt_lead++;
      else      cnt_trail++;
      if (lead ^ s_cpha) begin
         #1 s_rx = s_lsbf ? {mosi_o, s_rx[7:1]} : {s_rx[6:0], mosi_o};
      end
   end

   always @(posedge sck_o) if (rec_en) rise_q.push_back($time);

   always @* begin
      int idx;
      idx = s_cpha ? cnt_lead - 1 : cnt_trail;
      if (idx < 0) idx = 0;
      if (idx > 7) idx = 7;
      miso_i = loop_en ? mosi_o : (s_lsbf ? s_word[idx] : s_word[7-idx]);
   end

   task automatic bus(input logic [2:0] a, input logic w, input logic [7:0] d);
      @(posedge clk_i); #1;
      adr_i = a; we_i = w; dat_i = d; cyc_i = 1'b1; stb_i = 1'b1;
      @(posedge clk_i); #1;
      check("ack_high", 32'(ack_o), 1);
      @(posedge clk_i); #1;
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
      check("ack_low", 32'(ack_o), 0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      bus(a, 1'b1, d);
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] e, input string n);
      exp_q.push_back(e);
      name_q.push_back(n);
      bus(a, 1'b0, 8'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      time        span, gap, max_gap;
      logic [7:0] c;
      int         k, n;
      rst_i = 1'b0; adr_i = '0; cyc_i = 0; stb_i = 0; we_i = 0; dat_i = '0;
      loop_en = 1; cpol_tb = 0; s_cpha = 0; s_lsbf = 0; rec_en = 0;
      s_word = 8'h3C; s_rx = '0; cnt_lead = 0; cnt_trail = 0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ack", 32'(ack_o), 0);
      check("rst_sck", 32'(sck_o), 0);
      check("rst_ss", 32'(ss_n_o), 32'hF);
      check("rst_inta", 32'(inta_o), 0);
      check("rst_mosi", 32'(mosi_o), 0);
      check("rst_dat", 32'(dat_o), 0);
      rst_i = 1'b1;

      // 1: register reset values
      rd(3'd0, 8'h00, "rst_ctrl");
      rd(3'd1, 8'h05, "rst_stat");
      rd(3'd2, 8'h00, "rst_data_empty");
      rd(3'd3, 8'h00, "rst_div");
      rd(3'd4, 8'h00, "rst_ss_reg");

      // 2: loopback, mode 0, DIV=1
      wr(3'd3, 8'h01);
      wr(3'd4, 8'h01);
      check("t2_ss_n", 32'(ss_n_o), 32'hE);
      wr(3'd0, 8'h40);
      rise_q.delete();
      rec_en = 1;
      wr(3'd2, 8'hA5);
      repeat (60) @(posedge clk_i);
      rec_en = 0;
      check("t2_sck_pulses", rise_q.size(), 8);
      span = (rise_q.size() == 8) ? rise_q[7] - rise_q[0] : 0;
      check("t2_sck_span_ns", 32'(span), 280);
      rd(3'd1, 8'h84, "t2_stat_spif");
      rd(3'd2, 8'hA5, "t2_rx");
      rd(3'd1, 8'h85, "t2_stat_after_pop");
      wr(3'd1, 8'h80);
      rd(3'd1, 8'h05, "t2_stat_w1c");

      // 3: all modes, both bit orders, slave returns 0x3C
      loop_en = 0;
      s_word = 8'h3C;
      for (int m = 0; m < 4; m++) begin
         for (int l = 0; l < 2; l++) begin
            c = 8'h40 | 8'(l << 5) | 8'((m >> 1) << 3) | 8'((m & 1) << 2);
            cpol_tb = 1'(m >> 1);
            s_cpha  = 1'(m & 1);
            s_lsbf  = 1'(l);
            wr(3'd0, c);
            check($sformatf("t3_m%0d_l%0d_idle_sck", m, l), 32'(sck_o), 32'(m >> 1));
            cnt_lead = 0; cnt_trail = 0;
            wr(3'd2, 8'hA5);
            repeat (60) @(posedge clk_i);
            check($sformatf("t3_m%0d_l%0d_leads", m, l), 32'(cnt_lead), 8);
            check($sformatf("t3_m%0d_l%0d_mosi", m, l), 32'(s_rx), 32'hA5);
            rd(3'd2, 8'h3C, $sformatf("t3_m%0d_l%0d_rx", m, l));
         end
      end
      wr(3'd1, 8'hE0);

      // 4: TX overflow with SPE=0, then back-to-back drain
      cpol_tb = 0; s_cpha = 0; s_lsbf = 0; loop_en = 1;
      wr(3'd0, 8'h00);
      wr(3'd2, 8'h11); wr(3'd2, 8'h22); wr(3'd2, 8'h33); wr(3'd2, 8'h44); wr(3'd2, 8'h55);
      rd(3'd1, 8'h49, "t4_stat_wcol_full");
      wr(3'd1, 8'h40);
      rise_q.delete();
      rec_en = 1;
      wr(3'd0, 8'h40);
      repeat (200) @(posedge clk_i);
      rec_en = 0;
      check("t4_sck_pulses", rise_q.size(), 32);
      max_gap = 0;
      for (int i = 1; i < rise_q.size(); i++) begin
         gap = rise_q[i] - rise_q[i-1];
         if (gap > max_gap) max_gap = gap;
      end
      check("t4_max_gap_ns", 32'(max_gap), 60);
      rd(3'd1, 8'h86, "t4_stat_rxfull");
      rd(3'd2, 8'h11, "t4_rx0");
      rd(3'd2, 8'h22, "t4_rx1");
      rd(3'd2, 8'h33, "t4_rx2");
      rd(3'd2, 8'h44, "t4_rx3");
      wr(3'd1, 8'h80);

      // 5: RX overrun
      wr(3'd2, 8'h61); wr(3'd2, 8'h62); wr(3'd2, 8'h63); wr(3'd2, 8'h64); wr(3'd2, 8'h65);
      repeat (250) @(posedge clk_i);
      rd(3'd1, 8'hA6, "t5_stat_rovr");
      rd(3'd2, 8'h61, "t5_rx0");
      rd(3'd2, 8'h62, "t5_rx1");
      rd(3'd2, 8'h63, "t5_rx2");
      rd(3'd2, 8'h64, "t5_rx3");
      wr(3'd1, 8'h20);
      rd(3'd1, 8'h85, "t5_stat_rovr_clr");
      wr(3'd1, 8'h80);

      // 6: abort mid-word, then interrupt timing
      cnt_lead = 0; cnt_trail = 0;
      wr(3'd2, 8'h5A);
      wr(3'd2, 8'h77);
      k = 0;
      while (cnt_lead < 4 && k < 200) begin
         @(posedge clk_i);
         k++;
      end
      check("t6_reached_bit3", 32'(cnt_lead >= 4), 1);
      wr(3'd0, 8'h00);
      check("t6_abort_sck", 32'(sck_o), 0);
      n = cnt_lead;
      repeat (20) @(posedge clk_i);
      check("t6_no_more_sck", 32'(cnt_lead), 32'(n));
      rd(3'd1, 8'h05, "t6_stat_flushed");
      check("t6_ss_kept", 32'(ss_n_o), 32'hE);

      wr(3'd0, 8'hC0);
      wr(3'd2, 8'h3C);
      repeat (35) @(posedge clk_i);
      #1 check("t6_inta_before", 32'(inta_o), 0);
      @(posedge clk_i);
      #1 check("t6_inta_after", 32'(inta_o), 1);
      rd(3'd1, 8'h84, "t6_stat_spif");
      rd(3'd2, 8'h3C, "t6_rx");

      // Reset mid-transfer
      wr(3'd0, 8'h40);
      wr(3'd2, 8'h99);
      repeat (10) @(posedge clk_i);
      #3 rst_i = 1'b0;
      #1;
      check("rst_mid_sck", 32'(sck_o), 0);
      check("rst_mid_ss", 32'(ss_n_o), 32'hF);
      check("rst_mid_inta", 32'(inta_o), 0);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      rd(3'd1, 8'h05, "rst_mid_stat");
      rd(3'd0, 8'h00, "rst_mid_ctrl");

      repeat (5) @(posedge clk_i);
      check("scoreboard_drain", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
